// File: rtl/gpio_amm_pkg.sv
// gpio_amm_pkg: shared configuration, types and round-robin pick for the GPIO CSR arbiter.
package gpio_amm_pkg;
    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_ADDR_WIDTH  = 1;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MAX_PENDING = 4;
    localparam int MAX_MASTERS     = 8;
    localparam int IDX_W = (DEF_NUM_MASTERS > 1) ? $clog2(DEF_NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(DEF_MAX_PENDING + 1);
    typedef logic [IDX_W-1:0] idx_t;
    // Search starts just after the last winner and wraps over the n live masters.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                       input logic [2:0] last, input int n);
        logic [MAX_MASTERS-1:0] g;
        int idx;
        g = '0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && g == '0 && req[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction
endpackage

// File: rtl/gpio_amm_arbiter_if.sv
// gpio_amm_arbiter_if: master-side and slave-side Avalon-MM signals of the CSR arbiter.
interface gpio_amm_arbiter_if #(
    parameter int NUM_MASTERS = gpio_amm_pkg::DEF_NUM_MASTERS,
    parameter int ADDR_WIDTH  = gpio_amm_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = gpio_amm_pkg::DEF_DATA_WIDTH
);
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address_i;
    logic [NUM_MASTERS-1:0]            m_read_i;
    logic [NUM_MASTERS-1:0]            m_write_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata_i;
    logic [NUM_MASTERS-1:0]            m_waitrequest_o;
    logic [DATA_WIDTH-1:0]             m_readdata_o;
    logic [NUM_MASTERS-1:0]            m_readdatavalid_o;
    logic [ADDR_WIDTH-1:0]             s_address_o;
    logic                              s_read_o;
    logic                              s_write_o;
    logic [DATA_WIDTH-1:0]             s_writedata_o;
    logic                              s_waitrequest_i;
    logic [DATA_WIDTH-1:0]             s_readdata_i;
    logic                              s_readdatavalid_i;
    logic                              err_o;
    modport slave (
        input  m_address_i, m_read_i, m_write_i, m_writedata_i,
               s_waitrequest_i, s_readdata_i, s_readdatavalid_i,
        output m_waitrequest_o, m_readdata_o, m_readdatavalid_o,
               s_address_o, s_read_o, s_write_o, s_writedata_o, err_o
    );
    modport master (
        output m_address_i, m_read_i, m_write_i, m_writedata_i,
               s_waitrequest_i, s_readdata_i, s_readdatavalid_i,
        input  m_waitrequest_o, m_readdata_o, m_readdatavalid_o,
               s_address_o, s_read_o, s_write_o, s_writedata_o, err_o
    );
endinterface

// File: rtl/gpio_amm_id_fifo.sv
// gpio_amm_id_fifo: synchronous FIFO of master indices for outstanding reads.
module gpio_amm_id_fifo #(
    parameter int DEPTH = gpio_amm_pkg::DEF_MAX_PENDING,
    parameter int W     = gpio_amm_pkg::IDX_W,
    parameter int CW    = gpio_amm_pkg::CNT_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop_i) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign head_o  = mem_q[rp_q];
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/gpio_amm_arbiter.sv
// gpio_amm_arbiter: round-robin sharing of the GPIO CSR slave with in-order read response routing.
module gpio_amm_arbiter
    import gpio_amm_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) (
    input logic clk_i,
    input logic rst_i,
    gpio_amm_arbiter_if.slave bus
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MAX_PENDING + 1);
    logic [IW-1:0]          last_q, last_d, gidx, head;
    logic [NUM_MASTERS-1:0] req, elig, grant;
    logic [MAX_MASTERS-1:0] pick;
    logic [CW-1:0]          count;
    logic                   full, empty, pop, push, accept, err_q, err_d;
    always_comb begin
        req    = bus.m_read_i | bus.m_write_i;
        pop    = bus.s_readdatavalid_i & ~empty;
        // A pop in the same cycle frees the slot a new read would take.
        elig   = req & ~(bus.m_read_i & {NUM_MASTERS{full & ~pop}});
        pick   = rr_pick(MAX_MASTERS'(elig), 3'(last_q), NUM_MASTERS);
        grant  = pick[NUM_MASTERS-1:0];
        gidx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) if (grant[i]) gidx = IW'(i);
        accept = |grant & ~bus.s_waitrequest_i;
        push   = accept & |(grant & bus.m_read_i);
        last_d = accept ? gidx : last_q;
        err_d  = err_q | (bus.s_readdatavalid_i & (count == '0));
        bus.s_read_o          = |(grant & bus.m_read_i);
        bus.s_write_o         = |(grant & bus.m_write_i);
        bus.s_address_o       = bus.m_address_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_writedata_o     = bus.m_writedata_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        bus.m_waitrequest_o   = ~(grant & {NUM_MASTERS{~bus.s_waitrequest_i}});
        bus.m_readdatavalid_o = pop ? (NUM_MASTERS'(1) << head) : '0;
        bus.m_readdata_o      = bus.s_readdata_i;
        bus.err_o             = err_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IW'(NUM_MASTERS - 1);
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
        end
    end
    gpio_amm_id_fifo #(.DEPTH(MAX_PENDING), .W(IW), .CW(CW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (gidx),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
endmodule

// File: tb/tb_gpio_amm_arbiter.sv
// tb_gpio_amm_arbiter: directed scenario tests for the GPIO CSR round-robin arbiter.
module tb_gpio_amm_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    gpio_amm_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(1), .DATA_WIDTH(32)) bus ();
    gpio_amm_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk)
        if (!rst) assert (!(|(bus.m_read_i & bus.m_write_i))) else $error("master drove read and write together");
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle;
        bus.m_read_i = '0;
        bus.m_write_i = '0;
        bus.m_address_i = '0;
        bus.m_writedata_i = '0;
        bus.s_waitrequest_i = 1'b0;
        bus.s_readdata_i = '0;
        bus.s_readdatavalid_i = 1'b0;
    endtask
    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    task automatic test_reset;
        do_reset();
        #3;
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
        n_checks++; if (bus.m_readdatavalid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rdv: got %b expected 00", bus.m_readdatavalid_o); end
        n_checks++; if (dut.u_fifo.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", dut.u_fifo.count_o); end
        n_checks++; if ({bus.s_read_o, bus.s_write_o} !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: got %b expected 00", {bus.s_read_o, bus.s_write_o}); end
        n_checks++; if (bus.m_waitrequest_o !== 2'b11) begin n_fail++; $display("FAIL reset_wait: got %b expected 11", bus.m_waitrequest_o); end
    endtask
    task automatic test_single_write;
        bus.m_write_i = 2'b01;
        bus.m_address_i = 2'b01;
        bus.m_writedata_i = {32'h0, 32'hA5};
        #3;
        n_checks++; if (bus.s_write_o !== 1'b1) begin n_fail++; $display("FAIL sw_write: got %b expected 1", bus.s_write_o); end
        n_checks++; if (bus.s_writedata_o !== 32'hA5) begin n_fail++; $display("FAIL sw_data: got %h expected a5", bus.s_writedata_o); end
        n_checks++; if (bus.s_address_o !== 1'b1) begin n_fail++; $display("FAIL sw_addr: got %b expected 1", bus.s_address_o); end
        n_checks++; if (bus.m_waitrequest_o !== 2'b10) begin n_fail++; $display("FAIL sw_wait: got %b expected 10", bus.m_waitrequest_o); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b expected 0", bus.err_o); end
        tick();
        idle();
    endtask
    task automatic test_contention;
        do_reset();
        bus.m_write_i = 2'b11;
        bus.m_writedata_i = {32'h200, 32'h100};
        for (int k = 0; k < 6; k++) begin
            #3;
            n_checks++; if (bus.s_writedata_o !== ((k % 2) ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL cont_data%0d: got %h expected %h", k, bus.s_writedata_o, (k % 2) ? 32'h200 : 32'h100); end
            n_checks++; if (bus.m_waitrequest_o !== ((k % 2) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_wait%0d: got %b expected %b", k, bus.m_waitrequest_o, (k % 2) ? 2'b01 : 2'b10); end
            tick();
        end
        idle();
    endtask
    task automatic test_interleaved_reads;
        bus.m_read_i = 2'b10;
        #3;
        n_checks++; if ({bus.s_read_o, bus.m_waitrequest_o} !== 3'b101) begin n_fail++; $display("FAIL rd_m1_issue: got %b expected 101", {bus.s_read_o, bus.m_waitrequest_o}); end
        tick();
        bus.m_read_i = 2'b01;
        bus.s_readdatavalid_i = 1'b1;
        bus.s_readdata_i = 32'h11;
        #3;
        n_checks++; if (bus.m_waitrequest_o !== 2'b10) begin n_fail++; $display("FAIL rd_m0_issue: got %b expected 10", bus.m_waitrequest_o); end
        n_checks++; if (bus.m_readdatavalid_o !== 2'b10) begin n_fail++; $display("FAIL rd_rdv1: got %b expected 10", bus.m_readdatavalid_o); end
        n_checks++; if (bus.m_readdata_o !== 32'h11) begin n_fail++; $display("FAIL rd_data1: got %h expected 11", bus.m_readdata_o); end
        tick();
        bus.m_read_i = 2'b00;
        bus.s_readdata_i = 32'h22;
        #3;
        n_checks++; if (bus.m_readdatavalid_o !== 2'b01) begin n_fail++; $display("FAIL rd_rdv2: got %b expected 01", bus.m_readdatavalid_o); end
        n_checks++; if (bus.m_readdata_o !== 32'h22) begin n_fail++; $display("FAIL rd_data2: got %h expected 22", bus.m_readdata_o); end
        tick();
        bus.s_readdatavalid_i = 1'b0;
        #3;
        n_checks++; if (bus.m_readdatavalid_o !== 2'b00) begin n_fail++; $display("FAIL rd_idle: got %b expected 00", bus.m_readdatavalid_o); end
        n_checks++; if (dut.u_fifo.count_o !== 3'd0) begin n_fail++; $display("FAIL rd_count: got %0d expected 0", dut.u_fifo.count_o); end
        idle();
    endtask
    task automatic test_fifo_full;
        do_reset();
        bus.m_read_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #3;
            n_checks++; if (bus.m_waitrequest_o[0] !== 1'b0) begin n_fail++; $display("FAIL full_fill%0d: got %b expected 0", k, bus.m_waitrequest_o[0]); end
            tick();
        end
        n_checks++; if (dut.u_fifo.count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", dut.u_fifo.count_o); end
        #2;
        n_checks++; if ({bus.s_read_o, bus.m_waitrequest_o} !== 3'b011) begin n_fail++; $display("FAIL full_stall: got %b expected 011", {bus.s_read_o, bus.m_waitrequest_o}); end
        bus.m_write_i = 2'b10;
        bus.m_address_i = 2'b10;
        bus.m_writedata_i = {32'h77, 32'h0};
        #1;
        n_checks++; if ({bus.s_write_o, bus.m_waitrequest_o} !== 3'b101) begin n_fail++; $display("FAIL full_m1_write: got %b expected 101", {bus.s_write_o, bus.m_waitrequest_o}); end
        tick();
        bus.m_write_i = 2'b00;
        bus.s_readdatavalid_i = 1'b1;
        bus.s_readdata_i = 32'h33;
        #3;
        n_checks++; if ({bus.s_read_o, bus.m_waitrequest_o} !== 3'b110) begin n_fail++; $display("FAIL full_push_pop: got %b expected 110", {bus.s_read_o, bus.m_waitrequest_o}); end
        n_checks++; if (bus.m_readdatavalid_o !== 2'b01) begin n_fail++; $display("FAIL full_pop_rdv: got %b expected 01", bus.m_readdatavalid_o); end
        tick();
        bus.m_read_i = 2'b00;
        n_checks++; if (dut.u_fifo.count_o !== 3'd4) begin n_fail++; $display("FAIL full_count_same: got %0d expected 4", dut.u_fifo.count_o); end
        for (int k = 0; k < 4; k++) begin
            #3;
            n_checks++; if (bus.m_readdatavalid_o !== 2'b01) begin n_fail++; $display("FAIL full_drain%0d: got %b expected 01", k, bus.m_readdatavalid_o); end
            tick();
        end
        bus.s_readdatavalid_i = 1'b0;
        n_checks++; if (dut.u_fifo.count_o !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", dut.u_fifo.count_o); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", bus.err_o); end
        idle();
    endtask
    task automatic test_stall;
        do_reset();
        bus.m_write_i = 2'b11;
        bus.m_address_i = 2'b10;
        bus.m_writedata_i = {32'hBEEF, 32'hCAFE};
        #3;
        n_checks++; if (bus.m_waitrequest_o !== 2'b10) begin n_fail++; $display("FAIL stall_first: got %b expected 10", bus.m_waitrequest_o); end
        tick();
        bus.s_waitrequest_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            n_checks++; if ({bus.s_write_o, bus.s_address_o, bus.s_writedata_o} !== {1'b1, 1'b1, 32'hBEEF}) begin n_fail++; $display("FAIL stall_cmd%0d: got %b %b %h expected 1 1 beef", k, bus.s_write_o, bus.s_address_o, bus.s_writedata_o); end
            n_checks++; if (bus.m_waitrequest_o !== 2'b11) begin n_fail++; $display("FAIL stall_wait%0d: got %b expected 11", k, bus.m_waitrequest_o); end
            n_checks++; if (dut.last_q !== 1'b0) begin n_fail++; $display("FAIL stall_last%0d: got %b expected 0", k, dut.last_q); end
            tick();
        end
        bus.s_waitrequest_i = 1'b0;
        #3;
        n_checks++; if ({bus.m_waitrequest_o, bus.s_writedata_o} !== {2'b01, 32'hBEEF}) begin n_fail++; $display("FAIL stall_accept: got %b %h expected 01 beef", bus.m_waitrequest_o, bus.s_writedata_o); end
        tick();
        #2;
        n_checks++; if ({bus.m_waitrequest_o, bus.s_address_o, bus.s_writedata_o} !== {2'b10, 1'b0, 32'hCAFE}) begin n_fail++; $display("FAIL stall_next: got %b %b %h expected 10 0 cafe", bus.m_waitrequest_o, bus.s_address_o, bus.s_writedata_o); end
        idle();
    endtask
    task automatic test_errors;
        do_reset();
        bus.s_readdatavalid_i = 1'b1;
        bus.s_readdata_i = 32'h55;
        #3;
        n_checks++; if (bus.m_readdatavalid_o !== 2'b00) begin n_fail++; $display("FAIL err_stray_rdv: got %b expected 00", bus.m_readdatavalid_o); end
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b expected 0", bus.err_o); end
        tick();
        bus.s_readdatavalid_i = 1'b0;
        n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", bus.err_o); end
        tick();
        tick();
        n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err_o); end
        do_reset();
        n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", bus.err_o); end
        bus.m_read_i = 2'b01;
        tick();
        tick();
        bus.m_read_i = 2'b00;
        n_checks++; if (dut.u_fifo.count_o !== 3'd2) begin n_fail++; $display("FAIL err_pending: got %0d expected 2", dut.u_fifo.count_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (dut.u_fifo.count_o !== 3'd0) begin n_fail++; $display("FAIL err_reset_count: got %0d expected 0", dut.u_fifo.count_o); end
        bus.s_readdatavalid_i = 1'b1;
        #3;
        n_checks++; if (bus.m_readdatavalid_o !== 2'b00) begin n_fail++; $display("FAIL err_stale_rdv: got %b expected 00", bus.m_readdatavalid_o); end
        tick();
        bus.s_readdatavalid_i = 1'b0;
        n_checks++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_stale_set: got %b expected 1", bus.err_o); end
        idle();
    endtask
    initial begin
        idle();
        test_reset();
        test_single_write();
        test_contention();
        test_interleaved_reads();
        test_fifo_full();
        test_stall();
        test_errors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
